// File: rtl/multicycle_control_if.sv
// Control-side bundle between the multicycle MIPS control FSM and the datapath:
// IR fields and memory-ready in, datapath strobes and debug/status out.
interface multicycle_control_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  logic [5:0]         Opcode;
  logic [5:0]         func;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               BranchNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemToReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0]         State;
  logic               InstrDone;
  logic [CNT_W-1:0]   InstrCount;
  logic               Exception;

  modport slave (
    input  Opcode, func, MemReady,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           State, InstrDone, InstrCount, Exception
  );

  modport master (
    output Opcode, func, MemReady,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           State, InstrDone, InstrCount, Exception
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stalls and a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to send illegal instructions to a sticky TRAP state instead of a nop.
module multicycle_control #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

  state_t             state_reg, state_next;
  logic [5:0]         op_reg, fn_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               decode_illegal;
  logic               pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, exc;
  logic [1:0]         alu_src_b, pc_source;
  logic [ALUOP_W-1:0] alu_op;

  function automatic logic func_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [ALUOP_W-1:0] func_aluop(input logic [5:0] fn);
    case (fn)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      op_reg    <= '0;
      fn_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg <= bus.Opcode;
        fn_reg <= bus.func;
      end
      if (instr_done) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next     = state_reg;
    decode_illegal = 1'b0;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    branch_ne      = 1'b0;
    i_or_d         = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    mem_to_reg     = 1'b0;
    reg_dst        = 1'b0;
    reg_write      = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    pc_source      = 2'b00;
    alu_op         = ALU_ADD;
    instr_done     = 1'b0;
    exc            = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
        if (bus.MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the live IR fields pick the path.
        alu_src_b = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW:                    state_next = S_MEMADR;
          OP_BEQ, OP_BNE:                  state_next = S_BRANCH;
          OP_J:                            state_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = S_IEXEC;
          OP_R: begin
            if (func_legal(bus.func)) state_next = S_REXEC;
            else                      decode_illegal = 1'b1;
          end
          default:                         decode_illegal = 1'b1;
        endcase
        if (decode_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          instr_done = 1'b1;
          state_next = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (op_reg == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = bus.MemReady;
        if (bus.MemReady) state_next = S_FETCH;
      end
      S_REXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = func_aluop(fn_reg);
        state_next = S_RWB;
      end
      S_RWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (op_reg == OP_BNE);
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_reg)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        state_next = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        exc        = 1'b1;
        state_next = S_TRAP;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Everything is held low during reset so no write strobe leaks mid-instruction.
  assign bus.PCWrite     = ~rst & pc_write;
  assign bus.PCWriteCond = ~rst & pc_write_cond;
  assign bus.BranchNe    = ~rst & branch_ne;
  assign bus.IorD        = ~rst & i_or_d;
  assign bus.MemRead     = ~rst & mem_read;
  assign bus.MemWrite    = ~rst & mem_write;
  assign bus.IRWrite     = ~rst & ir_write;
  assign bus.MemToReg    = ~rst & mem_to_reg;
  assign bus.RegDst      = ~rst & reg_dst;
  assign bus.RegWrite    = ~rst & reg_write;
  assign bus.ALUSrcA     = ~rst & alu_src_a;
  assign bus.ALUSrcB     = rst ? 2'b00 : alu_src_b;
  assign bus.PCSource    = rst ? 2'b00 : pc_source;
  assign bus.ALUOp       = rst ? '0 : alu_op;
  assign bus.State       = rst ? 4'd0 : state_reg;
  assign bus.InstrDone   = ~rst & instr_done;
  assign bus.InstrCount  = rst ? '0 : cnt_reg;
  assign bus.Exception   = ~rst & exc;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised successor to the single-cycle opcode decoder: a multicycle MIPS control FSM that sequences fetch, decode, execute, memory and writeback over several clocks. It sits between the instruction register and the shared-memory datapath (single memory port, shared ALU, IR/PC registers). It waits on a memory-ready handshake and counts retired instructions. It decodes the same instruction set: R-type add/sub/and/or/slt, lw, sw, addi, slti, andi, ori, beq, bne, j.

Parameters:
ALUOP_W, 4, width of the ALUOp output. Codes are zero-extended: add=0, sub=1, and=2, or=3, slt=5. Must be >=3.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
Opcode  in  6  IR[31:26], valid from DECODE onward
func  in  6  IR[5:0]
MemReady  in  1  memory has completed the current read or write this cycle
PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-extended immediate, 11=immediate<<2
PCSource  out  2  00=ALU result, 01=ALUOut register, 10=jump target
ALUOp  out  ALUOP_W  ALU operation code
State  out  4  current state, for debug
InstrDone  out  1  one-cycle pulse when an instruction retires
InstrCount  out  CNT_W  number of retired instructions
Exception  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12.
- Outputs are combinational from the State register and the Opcode/func latched in DECODE. Any output not listed for a state is 0.
- Reset: State=FETCH, InstrCount=0, Exception=0, latched opcode/func=0. While rst=1 every output is forced to 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add. IRWrite and PCWrite equal MemReady. Advance to DECODE on MemReady, otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add. Latch Opcode and func. Next state:
  - lw/sw -> MEMADR
  - R-type -> REXEC
  - beq/bne -> BRANCH
  - j -> JUMP
  - addi/slti/andi/ori -> IEXEC
  - anything else -> illegal handling
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady, then MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, InstrDone=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady; InstrDone=MemReady. Next FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from func (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Next RWB.
- RWB: RegDst=1, RegWrite=1, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, BranchNe=(opcode==000101), InstrDone=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Next FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp is add for addi, slt for slti, and for andi, or for ori. Next IWB.
- IWB: RegDst=0, MemToReg=0, RegWrite=1, InstrDone=1. Next FETCH.
- Latency with zero wait states: lw 5 cycles, sw/R/I 4, beq/bne/j 3. Each MemReady-low cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- InstrCount increments on every InstrDone and wraps from 2^CNT_W-1 to 0.
- MemReady asserted outside FETCH, MEMRD or MEMWR is ignored.
- rst asserted mid-instruction returns State to FETCH on the next edge; no partial writes occur while rst=1.
- An R-type with an unknown func is illegal.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to TRAP. TRAP holds until reset, with Exception=1 and all strobes 0. Illegal instructions are not counted.
- Undefined: Exception is tied to 0. An illegal instruction goes DECODE -> FETCH with InstrDone=1 (treated as a nop) and is counted.

Test Plan:
- Reset, then MemReady=1, R-type add (func 100000): states 0,1,6,7; RegWrite=1 and RegDst=1 in RWB; InstrCount=1 after 4 cycles.
- lw with MemReady held low for 2 cycles in MEMRD: 7 cycles total; MemToReg=1 and RegWrite=1 only in MEMWB.
- sw then bne: MemWrite=1 only in MEMWR; in BRANCH, PCWriteCond=1, BranchNe=1, ALUOp=1.
- j: PCWrite=1 and PCSource=10 in cycle 3; InstrDone pulses once; ori gives ALUOp=3 in IEXEC.
- Opcode 111111: with ILLEGAL_TRAP_EN, State=12 and Exception=1 until rst; without it, returns to FETCH and InstrCount increments.
- With CNT_W=2, retire 5 instructions: InstrCount reads 1; assert rst in MEMRD: outputs 0 and State=0 on the next edge.
